// File: rtl/proc_data_mem.sv
// Data memory and boot loader behind simple_proc's bus: fills RAM from a load stream
// while holding the processor in reset, then serves reads and de-duplicated writes.
module proc_data_mem #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 8,
    parameter int DEPTH    = 1 << ADDRSIZE,
    parameter int CNTW     = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                load_valid,
    input  logic [WIDTH-1:0]    load_data,
    input  logic                load_last,
    output logic                load_ready,
    input  logic                restart,
    output logic                proc_nrst,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] address,
    input  logic [WIDTH-1:0]    dataout,
    output logic [WIDTH-1:0]    datain,
    output logic [CNTW-1:0]     wr_count,
    output logic                load_ovf
);

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [1:0]          state_q, state_d;
    logic [ADDRSIZE-1:0] ptr_q, ptr_d;
    logic                ready_q, ready_d;
    logic                pnrst_q, pnrst_d;
    logic                ovf_q, ovf_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]    datain_q;
    logic                last_we_q, last_we_d;
    logic [ADDRSIZE-1:0] last_addr_q, last_addr_d;
    logic [WIDTH-1:0]    last_data_q, last_data_d;

    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_wa;
    logic [WIDTH-1:0]    mem_wd;
    logic                rd_en;
    logic                commit;

    // The processor parks its bus between STRs, so only a changed bus (or a fresh
    // we rising edge) counts as a new write.
    assign commit = we && (!last_we_q || (address != last_addr_q) || (dataout != last_data_q));

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        last_we_d   = last_we_q;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        mem_we      = 1'b0;
        mem_wa      = ptr_q;
        mem_wd      = load_data;
        rd_en       = 1'b0;
        case (state_q)
            S_LOAD: begin
                if (load_valid && ready_q) begin
                    mem_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;
                    if (load_last || (ptr_q == LAST_ADDR)) begin
                        state_d = S_ARM;
                        if (!load_last) ovf_d = 1'b1;
                    end
                end
            end
            S_ARM: begin
                last_we_d   = we;
                last_addr_d = address;
                last_data_d = dataout;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (restart) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end else begin
                    last_we_d = we;
                    if (!we) begin
                        rd_en = 1'b1;
                    end else if (commit) begin
                        mem_we      = 1'b1;
                        mem_wa      = address;
                        mem_wd      = dataout;
                        cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
                        last_addr_d = address;
                        last_data_d = dataout;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
        // Handshake and processor reset are registered off the next state.
        ready_d = (state_d == S_LOAD);
        pnrst_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_LOAD;
            ptr_q       <= '0;
            ready_q     <= 1'b0;
            pnrst_q     <= 1'b0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            last_we_q   <= 1'b0;
            last_addr_q <= '0;
            last_data_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ready_q     <= ready_d;
            pnrst_q     <= pnrst_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            last_we_q   <= last_we_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)      datain_q <= '0;
        else if (rd_en) datain_q <= mem[address];
    end

    // RAM contents survive reset so a partial image is left in place.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    assign load_ready = ready_q;
    assign proc_nrst  = pnrst_q;
    assign datain     = datain_q;
    assign wr_count   = cnt_q;
    assign load_ovf   = ovf_q;

endmodule

// File: tb/tb_proc_data_mem.sv
// Randomized bench for proc_data_mem against a behavioural model of load/run rules.
module tb_proc_data_mem;
    localparam int W = 32;
    localparam int A = 8;
    localparam int D = 256;
    localparam int C = 16;
    localparam int PH_LOAD = 0, PH_ARM = 1, PH_RUN = 2;

    logic         clk = 1'b0, nrst = 1'b0;
    logic         load_valid = 1'b0, load_last = 1'b0, restart = 1'b0, we = 1'b0;
    logic [W-1:0] load_data = '0, dataout = '0;
    logic [A-1:0] address = '0;
    logic         load_ready, proc_nrst, load_ovf;
    logic [W-1:0] datain;
    logic [C-1:0] wr_count;

    proc_data_mem #(.WIDTH(W), .ADDRSIZE(A), .DEPTH(D), .CNTW(C)) dut (
        .clk(clk), .nrst(nrst),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .restart(restart), .proc_nrst(proc_nrst),
        .we(we), .address(address), .dataout(dataout), .datain(datain),
        .wr_count(wr_count), .load_ovf(load_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    // Reference model
    logic [W-1:0] m_mem [D];
    bit           m_wr  [D];
    int           m_phase, m_ptr, m_cnt;
    bit           m_ready, m_pn, m_ovf, m_dk, m_acc;
    logic [W-1:0] m_din;
    bit           m_lwe;
    int           m_la;
    logic [W-1:0] m_ld;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        check("load_ready", 32'(load_ready), 32'(m_ready));
        check("proc_nrst", 32'(proc_nrst), 32'(m_pn));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
        check("load_ovf", 32'(load_ovf), 32'(m_ovf));
        if (m_dk) check("datain", datain, m_din);
    endtask

    task automatic model_reset();
        m_phase = PH_LOAD; m_ptr = 0; m_cnt = 0;
        m_ready = 0; m_pn = 0; m_ovf = 0; m_din = '0; m_dk = 1; m_acc = 0;
        m_lwe = 0; m_la = 0; m_ld = '0;
    endtask

    // One clock of the spec's rules, using inputs as seen at the edge.
    task automatic model_step();
        int a;
        a = int'(address);
        m_acc = 0;
        if (m_phase == PH_LOAD) begin
            if (m_ready && load_valid) begin
                m_acc = 1;
                m_mem[m_ptr] = load_data; m_wr[m_ptr] = 1;
                if (load_last || m_ptr == D - 1) begin
                    if (!load_last) m_ovf = 1;
                    m_phase = PH_ARM;
                end
                m_ptr = (m_ptr + 1) % D;
            end
        end else if (m_phase == PH_ARM) begin
            m_lwe = we; m_la = a; m_ld = dataout;
            m_phase = PH_RUN;
        end else if (restart) begin
            m_phase = PH_LOAD; m_ptr = 0;
        end else begin
            if (!we) begin
                m_dk = m_wr[a];
                if (m_dk) m_din = m_mem[a];
            end else if (!m_lwe || a != m_la || dataout != m_ld) begin
                m_mem[a] = dataout; m_wr[a] = 1;
                if (m_cnt < (1 << C) - 1) m_cnt++;
                m_la = a; m_ld = dataout;
            end
            m_lwe = we;
        end
        m_ready = (m_phase == PH_LOAD);
        m_pn    = (m_phase == PH_RUN);
    endtask

    task automatic cyc(input logic lv, input logic [W-1:0] ld, input logic lst, input logic rs,
                       input logic w, input logic [A-1:0] a, input logic [W-1:0] d);
        load_valid = lv; load_data = ld; load_last = lst; restart = rs;
        we = w; address = a; dataout = d;
        @(posedge clk);
        model_step();
        #1 check_outs();
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic load_word(input logic [W-1:0] d, input logic lst);
        bit done;
        done = 0;
        for (int t = 0; t < 4 && !done; t++) begin
            cyc(1'b1, d, lst, 1'b0, 1'b0, '0, '0);
            done = m_acc;
        end
        if (!done) check("load_accept", 32'd0, 32'd1);
    endtask

    // Reset asserted mid-cycle; outputs must drop at once.
    task automatic do_reset();
        nrst = 1'b0;
        #1 model_reset();
        check_outs();
        #2 nrst = 1'b1;
    endtask

    initial begin
        logic [W-1:0] img [4];
        logic         rw;
        logic [A-1:0] ra;
        logic [W-1:0] rd;
        for (int i = 0; i < D; i++) m_wr[i] = 0;
        #1 do_reset();

        // 1: boot a 4-word image
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        idle();
        for (int i = 0; i < 4; i++) load_word(img[i], i == 3);
        check("arm_hold", 32'(proc_nrst), 32'd0);
        idle();
        check("run_entry", 32'(proc_nrst), 32'd1);

        // 2: read then hold datain through writes
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd2, '0);
        check("read_a2", datain, img[2]);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd2, $urandom);
        check("datain_hold", datain, img[2]);

        // 3: static write commits once, repeat after a read gap
        for (int i = 0; i < 10; i++) cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd5, 32'h1234);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd5, 32'h1234);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, 8'd5, 32'h1234);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd5, '0);
        check("read_a5", datain, 32'h1234);

        // Random bus traffic with frequent parking
        rw = 0; ra = '0; rd = '0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rw = 1'($urandom_range(0, 1));
                ra = A'($urandom_range(0, 7));
                rd = W'($urandom_range(0, 3));
            end
            cyc(1'b0, '0, 1'b0, 1'b0, rw, ra, rd);
        end

        // 5: restart while presenting a fresh write
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b1, 8'd9, 32'hdead_beef);
        check("restart_pn", 32'(proc_nrst), 32'd0);
        check("restart_ready", 32'(load_ready), 32'd1);

        // 4: fill every word without last -> overflow
        for (int i = 0; i < D; i++) load_word(W'(i) ^ 32'h5a00_0000, 1'b0);
        check("ovf_set", 32'(load_ovf), 32'd1);
        cyc(1'b1, 32'hffff_ffff, 1'b0, 1'b0, 1'b0, '0, '0);
        check("arm_no_ready", 32'(load_ready), 32'd0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
        check("ptr_from_zero", datain, 32'h5a00_0000);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd255, '0);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd9, '0);
        check("no_commit_on_restart", datain, 32'h5a00_0009);

        for (int i = 0; i < 100; i++)
            cyc(1'b0, '0, 1'b0, 1'b0, 1'($urandom_range(0, 1)),
                A'($urandom_range(0, 15)), W'($urandom_range(0, 1)));

        // 6: reset in the middle of a load, then a one-word image
        cyc(1'b0, '0, 1'b0, 1'b1, 1'b0, '0, '0);
        load_word($urandom, 1'b0);
        load_word($urandom, 1'b0);
        do_reset();
        load_word(32'hcafe_0001, 1'b1);
        idle();
        check("reload_run", 32'(proc_nrst), 32'd1);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
        check("reload_a0", datain, 32'hcafe_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
